// File: rtl/afe_pkg.sv
// Shared types and defaults for the AFE injection/readout scan controller.
package afe_pkg;

  localparam int unsigned SCLK_HALF_DEFAULT = 4;
  localparam int unsigned GAP_DEFAULT       = 16;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned SUM_W             = 16;
  localparam int unsigned BIT_IDX_W         = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INJ_HI,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP_WAIT,
    ST_FIN
  } scan_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_SHIFT,
    SPI_HOLD
  } spi_phase_e;

  // Per-scan settings captured on an accepted start.
  typedef struct packed {
    logic [BYTE_W-1:0] width;
    logic [BYTE_W-1:0] gpio;
  } scan_cfg_t;

  // INJ stays high from injection through the end of the readout so TOT is kept.
  function automatic logic inj_active(input scan_state_e s);
    return (s == ST_INJ_HI) || (s == ST_CS_SETUP) || (s == ST_SHIFT) || (s == ST_CS_HOLD);
  endfunction

endpackage

// File: rtl/afe_scan_ctrl_if.sv
// Host-side control/status bus and AFE-side pin bundle for the scan controller.
interface afe_host_if;
  import afe_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] n_inj;
  logic [BYTE_W-1:0] inj_width;
  logic [BYTE_W-1:0] cfg;
  logic              busy;
  logic              done;
  logic [BYTE_W-1:0] hit_count;
  logic [SUM_W-1:0]  tot_sum;
  logic [BYTE_W-1:0] tot_last;

  modport master (
    output start, n_inj, inj_width, cfg,
    input  busy, done, hit_count, tot_sum, tot_last
  );

  modport slave (
    input  start, n_inj, inj_width, cfg,
    output busy, done, hit_count, tot_sum, tot_last
  );
endinterface

interface afe_front_if;
  logic inj;
  logic hit;
  logic cs_b;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (
    output inj, cs_b, sclk, mosi,
    input  hit, miso
  );

  modport slave (
    input  inj, cs_b, sclk, mosi,
    output hit, miso
  );
endinterface

// File: rtl/afe_spi_master.sv
// One-byte SPI mode-0 transaction: CS setup cycle, 8 MSB-first SCLK periods, CS hold cycle.
module afe_spi_master
  import afe_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              go,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              done_c,
  output logic              cs_b,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [BYTE_W-1:0]    HALF_LAST = BYTE_W'(SCLK_HALF - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(BYTE_W - 1);

  spi_phase_e           phase_q, phase_d;
  logic [BYTE_W-1:0]    half_q, half_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic                 hi_q, hi_d;
  logic [BYTE_W-1:0]    tx_q, tx_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic                 cs_b_q, cs_b_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      phase_q <= SPI_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    half_d  = half_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    done_c  = 1'b0;

    unique case (phase_q)
      SPI_IDLE: begin
        if (go) begin
          phase_d = SPI_SETUP;
          tx_d    = tx_byte;
          half_d  = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
        end
      end
      SPI_SETUP: phase_d = SPI_SHIFT;
      SPI_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (!hi_q) begin
            // Last low-phase cycle: capture MISO just before the rising edge.
            hi_d = 1'b1;
            rx_d = {rx_q[BYTE_W-2:0], miso};
          end else begin
            hi_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              phase_d = SPI_HOLD;
              done_c  = 1'b1;
            end else begin
              bit_d = bit_q + BIT_IDX_W'(1);
            end
          end
        end else begin
          half_d = half_q + BYTE_W'(1);
        end
      end
      SPI_HOLD: phase_d = SPI_IDLE;
      default:  phase_d = SPI_IDLE;
    endcase

    // MOSI only moves when a new low phase begins, so it is stable across each rise.
    cs_b_d = (phase_d == SPI_IDLE);
    sclk_d = (phase_d == SPI_SHIFT) && hi_d;
    mosi_d = ((phase_d == SPI_SETUP) || (phase_d == SPI_SHIFT)) ? tx_d[BIT_LAST - bit_d] : 1'b0;
  end

  assign rx_byte = rx_q;
  assign cs_b    = cs_b_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: rtl/afe_scan_ctrl.sv
// Injection scan sequencer: pulses INJ, reads TOT back over SPI, accumulates hit/TOT results.
module afe_scan_ctrl
  import afe_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT,
  parameter int unsigned GAP       = GAP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_b,
  afe_host_if.slave    host,
  afe_front_if.master  afe
);

  localparam logic [BYTE_W-1:0] GAP_LAST = BYTE_W'(GAP - 1);

  scan_state_e       state_q, state_d;
  scan_cfg_t         cfg_q, cfg_d;
  logic [BYTE_W-1:0] left_q, left_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;
  logic              hit_s1_q, hit_s1_d;
  logic              hit_s2_q, hit_s2_d;
  logic              hit_smp_q, hit_smp_d;
  logic [BYTE_W-1:0] hit_count_q, hit_count_d;
  logic [SUM_W-1:0]  tot_sum_q, tot_sum_d;
  logic [BYTE_W-1:0] tot_last_q, tot_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inj_q, inj_d;
  logic              spi_go_c;
  logic              spi_done_c;
  logic [BYTE_W-1:0] spi_rx;

  afe_spi_master #(
    .SCLK_HALF (SCLK_HALF)
  ) u_spi (
    .clk     (clk),
    .rst_b   (rst_b),
    .go      (spi_go_c),
    .tx_byte (cfg_q.gpio),
    .rx_byte (spi_rx),
    .done_c  (spi_done_c),
    .cs_b    (afe.cs_b),
    .sclk    (afe.sclk),
    .mosi    (afe.mosi),
    .miso    (afe.miso)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      left_q      <= '0;
      cnt_q       <= '0;
      hit_s1_q    <= 1'b0;
      hit_s2_q    <= 1'b0;
      hit_smp_q   <= 1'b0;
      hit_count_q <= '0;
      tot_sum_q   <= '0;
      tot_last_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inj_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      hit_s1_q    <= hit_s1_d;
      hit_s2_q    <= hit_s2_d;
      hit_smp_q   <= hit_smp_d;
      hit_count_q <= hit_count_d;
      tot_sum_q   <= tot_sum_d;
      tot_last_q  <= tot_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inj_q       <= inj_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    left_d      = left_q;
    cnt_d       = cnt_q;
    hit_s1_d    = afe.hit;
    hit_s2_d    = hit_s1_q;
    hit_smp_d   = hit_smp_q;
    hit_count_d = hit_count_q;
    tot_sum_d   = tot_sum_q;
    tot_last_d  = tot_last_q;
    spi_go_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          cfg_d.width = (host.inj_width == '0) ? BYTE_W'(1) : host.inj_width;
          cfg_d.gpio  = host.cfg;
          left_d      = host.n_inj;
          cnt_d       = '0;
          hit_count_d = '0;
          tot_sum_d   = '0;
          tot_last_d  = '0;
          state_d     = (host.n_inj == '0) ? ST_FIN : ST_INJ_HI;
        end
      end
      ST_INJ_HI: begin
        if (cnt_q == cfg_q.width - BYTE_W'(1)) begin
          cnt_d    = '0;
          spi_go_c = 1'b1;
          state_d  = ST_CS_SETUP;
        end else begin
          cnt_d = cnt_q + BYTE_W'(1);
        end
      end
      ST_CS_SETUP: begin
        hit_smp_d = hit_s2_q;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (spi_done_c) state_d = ST_CS_HOLD;
      end
      ST_CS_HOLD: begin
        tot_last_d  = spi_rx;
        tot_sum_d   = tot_sum_q + SUM_W'(spi_rx);
        hit_count_d = hit_count_q + BYTE_W'(hit_smp_q);
        left_d      = left_q - BYTE_W'(1);
        cnt_d       = '0;
        state_d     = ST_GAP_WAIT;
      end
      ST_GAP_WAIT: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (left_q == '0) ? ST_FIN : ST_INJ_HI;
        end else begin
          cnt_d = cnt_q + BYTE_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // DONE is issued the cycle after FIN so the results are already settled.
    inj_d  = inj_active(state_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIN);
  end

  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.hit_count = hit_count_q;
  assign host.tot_sum   = tot_sum_q;
  assign host.tot_last  = tot_last_q;
  assign afe.inj        = inj_q;

endmodule

// File: tb/tb_afe_scan_ctrl.sv
// Randomized self-checking bench for afe_scan_ctrl with an AFE SPI slave model.
module tb_afe_scan_ctrl;
  import afe_pkg::*;

  localparam int unsigned H = 4;
  localparam int unsigned G = 16;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  afe_host_if  u_host ();
  afe_front_if u_afe ();

  afe_scan_ctrl #(
    .SCLK_HALF (H),
    .GAP       (G)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .host  (u_host.slave),
    .afe   (u_afe.master)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // AFE slave: TOT byte per injection, MSB first, shifted on SCLK rise; GPIO latched on CS_B rise.
  logic [7:0] tot_tab [256];
  bit         hit_tab [256];
  logic [7:0] ptr = 8'd0;
  logic [7:0] base = 8'd0;
  logic [7:0] sl_tx = 8'd0;
  logic [7:0] sl_rx = 8'd0;
  logic [7:0] gpio = 8'd0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  int         sclk_rises = 0;

  assign u_afe.hit = hit_tab[8'(ptr - base)];

  always @(u_afe.cs_b, u_afe.sclk) begin
    if (prev_cs === 1'b1 && u_afe.cs_b === 1'b0) begin
      sl_tx = tot_tab[8'(ptr - base)];
      u_afe.miso = sl_tx[7];
    end
    if (prev_sclk === 1'b0 && u_afe.sclk === 1'b1) begin
      sclk_rises++;
      if (u_afe.cs_b === 1'b0) begin
        sl_rx = {sl_rx[6:0], u_afe.mosi};
        sl_tx = {sl_tx[6:0], 1'b0};
        u_afe.miso = sl_tx[7];
      end
    end
    if (prev_cs === 1'b0 && u_afe.cs_b === 1'b1) begin
      gpio = sl_rx;
      ptr  = ptr + 8'd1;
    end
    prev_cs   = u_afe.cs_b;
    prev_sclk = u_afe.sclk;
  end

  // Pin monitor: INJ pulse lengths, INJ low gaps, DONE pulses, MOSI movement while SCLK high.
  int   exp_pulse_len = 0;
  int   inj_run = 0;
  int   gap_run = 1000;
  int   pulses = 0;
  int   bad_pulse = 0;
  int   short_gap = 0;
  int   done_seen = 0;
  int   mosi_bad = 0;
  logic prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (u_afe.inj === 1'b1) begin
      if (inj_run == 0 && gap_run < int'(G)) short_gap++;
      inj_run++;
      gap_run = 0;
    end else begin
      if (inj_run > 0) begin
        pulses++;
        if (inj_run != exp_pulse_len) bad_pulse++;
      end
      inj_run = 0;
      if (gap_run < 1000) gap_run++;
    end
    if (u_host.done === 1'b1) done_seen++;
    if (u_afe.sclk === 1'b1 && u_afe.mosi !== prev_mosi) mosi_bad++;
    prev_mosi = u_afe.mosi;
  end

  task automatic run_scan(input string tag, input int n, input int w, input logic [7:0] cfgv,
                          input bit spurious, input bit churn);
    int wn, exp_cyc, cyc, limit, exp_hits, exp_sum;
    int p0, b0, s0, d0, r0, m0;
    logic [7:0] exp_last;
    wn            = (w == 0) ? 1 : w;
    exp_pulse_len = wn + 2 + 16 * int'(H);
    exp_cyc       = 2 + n * (wn + 2 + 16 * int'(H) + int'(G));
    limit         = exp_cyc + 50;
    exp_hits = 0;
    exp_sum  = 0;
    exp_last = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_hits += int'(hit_tab[i]);
      exp_sum  += int'(tot_tab[i]);
      exp_last  = tot_tab[i];
    end
    base = ptr;
    p0 = pulses; b0 = bad_pulse; s0 = short_gap; d0 = done_seen; r0 = sclk_rises; m0 = mosi_bad;
    u_host.n_inj     = 8'(n);
    u_host.inj_width = 8'(w);
    u_host.cfg       = cfgv;
    u_host.start     = 1'b1;
    tick();
    u_host.start = 1'b0;
    cyc = 1;
    check_val({tag, "_busy"}, 32'(u_host.busy), 32'd1);
    while (u_host.done !== 1'b1 && cyc < limit) begin
      if (churn) begin
        u_host.n_inj     = 8'($urandom);
        u_host.inj_width = 8'($urandom);
        u_host.cfg       = 8'($urandom);
      end
      u_host.start = spurious && (cyc == 1);
      tick();
      cyc++;
    end
    u_host.start = 1'b0;
    check_val({tag, "_done_time"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, "_busy_at_done"}, 32'(u_host.busy), 32'd0);
    check_val({tag, "_hit_count"}, 32'(u_host.hit_count), 32'(exp_hits));
    check_val({tag, "_tot_sum"}, 32'(u_host.tot_sum), 32'(exp_sum));
    check_val({tag, "_tot_last"}, 32'(u_host.tot_last), 32'(exp_last));
    tick();
    check_val({tag, "_done_width"}, 32'(u_host.done), 32'd0);
    check_val({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    check_val({tag, "_inj_pulses"}, 32'(pulses - p0), 32'(n));
    check_val({tag, "_inj_len_bad"}, 32'(bad_pulse - b0), 32'd0);
    check_val({tag, "_inj_gap_short"}, 32'(short_gap - s0), 32'd0);
    check_val({tag, "_sclk_rises"}, 32'(sclk_rises - r0), 32'(8 * n));
    check_val({tag, "_mosi_moves_high"}, 32'(mosi_bad - m0), 32'd0);
    if (n > 0) check_val({tag, "_gpio"}, 32'(gpio), 32'(cfgv));
  endtask

  initial begin
    int r0, r1, k;
    u_host.start     = 1'b0;
    u_host.n_inj     = 8'd0;
    u_host.inj_width = 8'd0;
    u_host.cfg       = 8'd0;
    for (int i = 0; i < 256; i++) begin
      tot_tab[i] = 8'd0;
      hit_tab[i] = 1'b0;
    end
    rst_b = 1'b0;
    repeat (3) tick();
    check_val("rst_inj", 32'(u_afe.inj), 32'd0);
    check_val("rst_cs_b", 32'(u_afe.cs_b), 32'd1);
    check_val("rst_sclk", 32'(u_afe.sclk), 32'd0);
    check_val("rst_mosi", 32'(u_afe.mosi), 32'd0);
    check_val("rst_busy", 32'(u_host.busy), 32'd0);
    check_val("rst_done", 32'(u_host.done), 32'd0);
    check_val("rst_hit_count", 32'(u_host.hit_count), 32'd0);
    check_val("rst_tot_sum", 32'(u_host.tot_sum), 32'd0);
    check_val("rst_tot_last", 32'(u_host.tot_last), 32'd0);
    rst_b = 1'b1;
    repeat (2) tick();

    tot_tab[0] = 8'h5A;
    hit_tab[0] = 1'b1;
    run_scan("single", 1, 10, 8'hC3, 1'b0, 1'b0);

    for (int i = 0; i < 255; i++) begin
      tot_tab[i] = 8'hFF;
      hit_tab[i] = 1'b1;
    end
    run_scan("multi", 255, 2, 8'h96, 1'b1, 1'b1);

    tot_tab[0] = 8'd3; tot_tab[1] = 8'd0; tot_tab[2] = 8'd7; tot_tab[3] = 8'd0;
    hit_tab[0] = 1'b1; hit_tab[1] = 1'b0; hit_tab[2] = 1'b1; hit_tab[3] = 1'b0;
    run_scan("mixed", 4, 5, 8'h3C, 1'b0, 1'b0);

    run_scan("zero", 0, 7, 8'hA5, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 8; i++) begin
        tot_tab[i] = 8'($urandom);
        hit_tab[i] = 1'($urandom);
      end
      run_scan($sformatf("rand%0d", s), int'($urandom_range(1, 6)), int'($urandom_range(0, 12)),
               8'($urandom), s[0], s[1]);
    end

    // Abort in the middle of the second readout, three SCLK rises into its shift.
    tot_tab[0] = 8'h81; tot_tab[1] = 8'h7E;
    hit_tab[0] = 1'b1;  hit_tab[1] = 1'b1;
    exp_pulse_len = 3 + 2 + 16 * int'(H);
    base = ptr;
    r0 = sclk_rises;
    u_host.n_inj     = 8'd2;
    u_host.inj_width = 8'd3;
    u_host.cfg       = 8'h55;
    u_host.start     = 1'b1;
    tick();
    u_host.start = 1'b0;
    k = 0;
    while (sclk_rises - r0 < 11 && k < 2000) begin
      tick();
      k++;
    end
    check_val("rst_wait_rises", 32'(sclk_rises - r0), 32'd11);
    check_val("pre_rst_hit_count", 32'(u_host.hit_count), 32'd1);
    check_val("pre_rst_tot_last", 32'(u_host.tot_last), 32'h81);
    rst_b = 1'b0;
    tick();
    r1 = sclk_rises;
    check_val("abort_inj", 32'(u_afe.inj), 32'd0);
    check_val("abort_cs_b", 32'(u_afe.cs_b), 32'd1);
    check_val("abort_sclk", 32'(u_afe.sclk), 32'd0);
    check_val("abort_busy", 32'(u_host.busy), 32'd0);
    check_val("abort_hit_count", 32'(u_host.hit_count), 32'd0);
    check_val("abort_tot_sum", 32'(u_host.tot_sum), 32'd0);
    check_val("abort_tot_last", 32'(u_host.tot_last), 32'd0);
    rst_b = 1'b1;
    repeat (40) tick();
    check_val("abort_no_sclk", 32'(sclk_rises - r1), 32'd0);
    check_val("abort_stays_idle", 32'(u_host.busy), 32'd0);
    check_val("abort_inj_low", 32'(u_afe.inj), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
